// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] HALT_OPCODE_DEF  = 8'h7F;
   localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 8'h00;

   // Fetch FSM state encoding.
   typedef logic [1:0] state_t;
   localparam state_t S_OP   = 2'd0;
   localparam state_t S_IMM  = 2'd1;
   localparam state_t S_HOLD = 2'd2;
   localparam state_t S_HALT = 2'd3;

   // Opcodes with the MSB set carry one immediate byte.
   function automatic logic is_two_byte(input logic [DATA_W-1:0] opcode);
      return opcode[DATA_W-1];
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over increment, otherwise hold.
module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // PC update; increment wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VECTOR;
      end else if (load) begin
         pc <= load_addr;
      end else if (inc) begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, assembles 1/2-byte instructions
// from the combinational ROM and hands them to the decoder via valid/ready.
// Optional instruction counter output enabled by defining FETCH_PERF_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [DATA_W-1:0] HALT_OPCODE  = HALT_OPCODE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              jmp_valid,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_opcode,
   output logic [DATA_W-1:0] out_imm,
   output logic [ADDR_W-1:0] out_pc,
   output logic              halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       instr_count
`endif
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] opcode_q;
   logic [DATA_W-1:0] imm_q;
   logic [ADDR_W-1:0] out_pc_q;
   logic [ADDR_W-1:0] pc;
   logic              handshake;
   logic              pc_inc;

   assign handshake = (state_q == S_HOLD) && out_ready;
   // Bytes are consumed only in the capture states, and never on a redirect.
   assign pc_inc    = !jmp_valid && ((state_q == S_OP) || (state_q == S_IMM));

   pc_reg #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (jmp_valid),
      .load_addr (jmp_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   // Next-state logic; a jump overrides everything, including a completing handshake.
   always_comb begin
      state_d = state_q;
      if (jmp_valid) begin
         state_d = S_OP;
      end else begin
         unique case (state_q)
            S_OP:    state_d = is_two_byte(rom_data) ? S_IMM : S_HOLD;
            S_IMM:   state_d = S_HOLD;
            S_HOLD: begin
               if (handshake) begin
                  state_d = (opcode_q == HALT_OPCODE) ? S_HALT : S_OP;
               end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_OP;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OP;
      end else begin
         state_q <= state_d;
      end
   end

   // Instruction capture; the registers only change while out_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q <= '0;
         imm_q    <= '0;
         out_pc_q <= '0;
      end else if (!jmp_valid) begin
         if (state_q == S_OP) begin
            opcode_q <= rom_data;
            imm_q    <= '0;
            out_pc_q <= pc;
         end else if (state_q == S_IMM) begin
            imm_q <= rom_data;
         end
      end
   end

   assign rom_addr   = pc;
   assign out_valid  = (state_q == S_HOLD);
   assign halted     = (state_q == S_HALT);
   assign out_opcode = opcode_q;
   assign out_imm    = imm_q;
   assign out_pc     = out_pc_q;

`ifdef FETCH_PERF_EN
   logic [15:0] instr_count_q;

   // Saturating count of delivered instructions; jumps do not affect it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count_q <= '0;
      end else if (handshake && (instr_count_q != 16'hFFFF)) begin
         instr_count_q <= instr_count_q + 16'd1;
      end
   end

   assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural ROM.
module tb_fetch_unit;

   logic       clk;
   logic       rst_n;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic       jmp_valid;
   logic [7:0] jmp_addr;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_opcode;
   logic [7:0] out_imm;
   logic [7:0] out_pc;
   logic       halted;
`ifdef FETCH_PERF_EN
   logic [15:0] instr_count;
`endif

   logic [7:0] rom [256];
   int n_tests;
   int n_fail;

   assign rom_data = rom[rom_addr];

   fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .jmp_valid  (jmp_valid),
      .jmp_addr   (jmp_addr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_imm    (out_imm),
      .out_pc     (out_pc),
      .halted     (halted)
`ifdef FETCH_PERF_EN
      ,
      .instr_count (instr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_held(input string tag, input logic [7:0] op, input logic [7:0] imm,
                             input logic [7:0] pc);
      check({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
      check({tag, ".opcode"}, {8'd0, out_opcode}, {8'd0, op});
      check({tag, ".imm"}, {8'd0, out_imm}, {8'd0, imm});
      check({tag, ".pc"}, {8'd0, out_pc}, {8'd0, pc});
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[8'h00] = 8'h12;
      rom[8'h01] = 8'h85;
      rom[8'h02] = 8'h3C;
      rom[8'h03] = 8'h01;
      rom[8'h05] = 8'h7F;
      rom[8'h10] = 8'h9A;
      rom[8'h11] = 8'hEE;
      rom[8'h20] = 8'h33;
      rom[8'h30] = 8'h44;
      rom[8'h40] = 8'h21;
      rom[8'h60] = 8'h01;
      rom[8'hFF] = 8'hA0;
      jmp_valid = 1'b0;
      jmp_addr  = 8'h00;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;

      // Reset state
      check("rst.valid", {15'd0, out_valid}, 16'd0);
      check("rst.halted", {15'd0, halted}, 16'd0);
      check("rst.rom_addr", {8'd0, rom_addr}, 16'h0000);
      check("rst.opcode", {8'd0, out_opcode}, 16'h0000);
      check("rst.imm", {8'd0, out_imm}, 16'h0000);
      check("rst.pc", {8'd0, out_pc}, 16'h0000);
`ifdef FETCH_PERF_EN
      check("rst.count", instr_count, 16'd0);
`endif

      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;

      // Straight-line: 1-byte 12 @00, then 2-byte 85 3C @01
      tick();
      check_held("sl1", 8'h12, 8'h00, 8'h00);
      check("sl1.rom_addr", {8'd0, rom_addr}, 16'h0001);
      tick();
      check("sl1.drop", {15'd0, out_valid}, 16'd0);
      tick();
      check("sl2.imm_phase", {15'd0, out_valid}, 16'd0);
      tick();
      check_held("sl2", 8'h85, 8'h3C, 8'h01);
      check("sl2.rom_addr", {8'd0, rom_addr}, 16'h0003);

      // Backpressure for 5 cycles
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_held("bp", 8'h85, 8'h3C, 8'h01);
         check("bp.rom_addr", {8'd0, rom_addr}, 16'h0003);
      end
      out_ready = 1'b1;
      tick();
      check("bp.accept", {15'd0, out_valid}, 16'd0);
      check("bp.rom_addr_after", {8'd0, rom_addr}, 16'h0003);

      // Wrap-around: A0 at FF takes immediate from 00
      rom[8'h00] = 8'h55;
      jmp_valid  = 1'b1;
      jmp_addr   = 8'hFF;
      tick();
      jmp_valid = 1'b0;
      check("wrap.valid", {15'd0, out_valid}, 16'd0);
      check("wrap.rom_addr_ff", {8'd0, rom_addr}, 16'h00FF);
      tick();
      check("wrap.rom_addr_00", {8'd0, rom_addr}, 16'h0000);
      tick();
      check_held("wrap", 8'hA0, 8'h55, 8'hFF);
      check("wrap.rom_addr", {8'd0, rom_addr}, 16'h0001);
      tick();

      // Jump during immediate fetch of 2-byte opcode at 10
      jmp_valid = 1'b1;
      jmp_addr  = 8'h10;
      tick();
      jmp_valid = 1'b0;
      tick();
      check("jimm.in_imm", {15'd0, out_valid}, 16'd0);
      check("jimm.rom_addr", {8'd0, rom_addr}, 16'h0011);
      jmp_valid = 1'b1;
      jmp_addr  = 8'h40;
      tick();
      jmp_valid = 1'b0;
      check("jimm.flushed", {15'd0, out_valid}, 16'd0);
      check("jimm.rom_addr40", {8'd0, rom_addr}, 16'h0040);
      tick();
      check_held("jimm", 8'h21, 8'h00, 8'h40);

      // Jump to 05 coincident with handshake of 21, then halt
      jmp_valid = 1'b1;
      jmp_addr  = 8'h05;
      tick();
      jmp_valid = 1'b0;
      check("hs_jmp.valid", {15'd0, out_valid}, 16'd0);
      tick();
      check_held("halt_op", 8'h7F, 8'h00, 8'h05);
      tick();
      for (int i = 0; i < 10; i++) begin
         check("halt.halted", {15'd0, halted}, 16'd1);
         check("halt.valid", {15'd0, out_valid}, 16'd0);
         check("halt.rom_addr", {8'd0, rom_addr}, 16'h0006);
         tick();
      end
      jmp_valid = 1'b1;
      jmp_addr  = 8'h20;
      tick();
      jmp_valid = 1'b0;
      check("resume.halted", {15'd0, halted}, 16'd0);
      check("resume.rom_addr", {8'd0, rom_addr}, 16'h0020);
      out_ready = 1'b0;
      tick();
      check_held("resume", 8'h33, 8'h00, 8'h20);

      // Flush a held instruction without out_ready
      jmp_valid = 1'b1;
      jmp_addr  = 8'h30;
      tick();
      jmp_valid = 1'b0;
      check("flush.valid", {15'd0, out_valid}, 16'd0);
      tick();
      check_held("flush", 8'h44, 8'h00, 8'h30);

      // Back-to-back jumps: last target wins
      jmp_valid = 1'b1;
      jmp_addr  = 8'h50;
      tick();
      jmp_addr = 8'h60;
      tick();
      jmp_valid = 1'b0;
      check("jj.valid", {15'd0, out_valid}, 16'd0);
      check("jj.rom_addr", {8'd0, rom_addr}, 16'h0060);
      tick();
      check_held("jj", 8'h01, 8'h00, 8'h60);
`ifdef FETCH_PERF_EN
      check("perf.count", instr_count, 16'd5);
`endif

      // Asynchronous reset while holding
      rst_n = 1'b0;
      #1;
      check("arst.valid", {15'd0, out_valid}, 16'd0);
      check("arst.rom_addr", {8'd0, rom_addr}, 16'h0000);
      check("arst.opcode", {8'd0, out_opcode}, 16'h0000);
`ifdef FETCH_PERF_EN
      check("arst.count", instr_count, 16'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_held("post_rst", 8'h55, 8'h00, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
